edubos5_mem_arb: RTL and testbench
==================================

Name: edubos5_mem_arb

Overview:
Arbiter and sequencer that shares one single-port memory bus between the eduBOS5 instruction-fetch port and the load/store (data) port. Data requests have fixed priority, and an anti-starvation counter bounds how long fetch can be blocked. One transaction is outstanding at a time. A watchdog aborts transactions the memory never acknowledges.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (legal range 1..15).
ACK_TIMEOUT, 255, cycles in BUSY without m_ack before abort; 0 disables the watchdog (legal range 0..65535).

Ports:
clk  in  1  system clock, all state on rising edge
arst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with stable i_addr until i_gnt
i_addr  in  30  fetch word address (cpu_pc_t, bits [31:2])
i_gnt  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch instruction word
d_req  in  1  data request; d_addr/d_we_bs/d_wdata held stable until d_gnt
d_addr  in  32  data byte address
d_we_bs  in  4  write-enable byte select (we_bs_t); NOWR = read
d_wdata  in  32  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data completion pulse, for reads and writes
d_rdata  out  32  load data
m_req  out  1  memory request, held until m_ack
m_addr  out  32  memory byte address
m_we_bs  out  4  memory byte write enables
m_wdata  out  32  memory write data
m_ack  in  1  memory completion; m_rdata valid in same cycle
m_rdata  in  32  memory read data
bus_err  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (arst_n=0, async):
  - State IDLE; streak and watchdog counters 0.
  - All outputs 0; this includes i_gnt/d_gnt, which are combinational and forced low while in reset.
  - Reset mid-transaction drops the transaction silently: no rvalid, no bus_err.
- FSM states: IDLE, BUSY.
- IDLE:
  - Winner selection, combinational on req inputs:
    - d_req only -> data.
    - i_req only -> fetch.
    - Both -> data, unless streak == MAX_DATA_STREAK, in which case fetch.
  - Winner's gnt is asserted in the same cycle. Owner and request fields are registered; next state BUSY.
  - Fetch capture: m_addr = {i_addr, 2'b00}, m_we_bs = 4'b0000, m_wdata = 0.
  - Data capture: m_addr = d_addr, m_we_bs = d_we_bs, m_wdata = d_wdata.
- Streak counter:
  - Data grant while i_req=1 -> streak+1.
  - Data grant while i_req=0, or any fetch grant -> streak=0.
  - Counter saturates at MAX_DATA_STREAK.
- BUSY:
  - m_req=1 with registered fields; no gnt is issued and requester inputs are ignored.
  - On m_ack=1:
    - If owner is fetch, or owner is data and m_we_bs == 0: capture m_rdata into the owner's rdata register.
    - Next cycle: the owner's rvalid pulses, m_req=0, state IDLE.
  - A new grant may occur in the same cycle as the rvalid pulse.
  - Best-case latency is req/gnt at cycle N, m_req at N+1, m_ack at N+1, rvalid at N+2. Peak throughput is one transaction per 2 cycles.
- Watchdog (ACK_TIMEOUT>0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without m_ack.
  - When it reaches ACK_TIMEOUT: next cycle m_req=0, state IDLE, bus_err=1 and owner rvalid=1 (both 1 cycle). Owner rdata is set to 32'h0000_0013 for fetch (NOP) and 0 for data.
  - m_ack arriving in the same cycle as the timeout wins: normal completion, no error.
- rdata registers:
  - Updated only on read completion or abort.
  - Hold their value otherwise, including after writes.
  - d_rdata is unchanged by a write's d_rvalid.
- m_addr/m_we_bs/m_wdata keep their last values when m_req=0.
- Protocol assertions in the bench:
  - req must not fall, and request fields must not change, while req=1 and gnt=0.
  - gnt and rvalid are never asserted to both requesters in one cycle.
  - m_req never falls without m_ack, except on abort.

Test Plan:
1. i_req=1, i_addr=30'h0000_0040, m_ack one cycle after m_req, m_rdata=32'h00A0_0093 -> i_gnt@N, m_addr=32'h0000_0100 and m_we_bs=0 @N+1, i_rvalid with i_rdata=32'h00A0_0093 @N+2.
2. d_req store d_addr=32'h0000_2004, d_we_bs=4'b1100, d_wdata=32'hDEAD_BEEF -> m_we_bs=4'b1100, m_wdata=32'hDEAD_BEEF; d_rvalid pulses; d_rdata keeps its prior value 32'h1234_5678.
3. i_req and d_req held continuously, MAX_DATA_STREAK=4, m_ack immediate -> grant order D,D,D,D,I,D,D,D,D,I; no gap cycles beyond the 2-cycle cadence.
4. Data read with m_ack withheld, ACK_TIMEOUT=8 -> m_req high for exactly 8 cycles, then bus_err and d_rvalid pulse together with d_rdata=0; FSM back in IDLE and the next request is granted.
5. m_ack asserted exactly on the timeout cycle -> normal completion, bus_err stays 0, m_rdata is delivered.
6. arst_n pulsed low while BUSY with m_req=1 -> all outputs 0 immediately, no rvalid or bus_err after release, first request after reset granted with streak=0.

Source files
------------

// File: rtl/edubos5_mem_arb.sv
// eduBOS5 memory arbiter: shares one single-port memory bus between the
// instruction-fetch port and the load/store port. Data has fixed priority,
// bounded by a streak counter so fetch cannot starve. One transaction is
// outstanding at a time; a watchdog aborts transactions that never get m_ack.
module edubos5_mem_arb #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned ACK_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we_bs,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we_bs,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);
    // Watchdog fires in the BUSY cycle where the counter reaches its last value.
    localparam logic [15:0] WD_LAST    = 16'(ACK_TIMEOUT - 1);
    localparam logic        WD_EN      = (ACK_TIMEOUT != 0);
    localparam logic [31:0] FETCH_NOP  = 32'h0000_0013;

    logic        state_q;
    logic        owner_q;  // 1 = data port owns the bus, 0 = fetch
    logic [3:0]  streak_q;
    logic [15:0] wd_q;
    logic        i_rvalid_q, d_rvalid_q, bus_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic [31:0] m_addr_q, m_wdata_q;
    logic [3:0]  m_we_bs_q;

    logic data_win, fetch_win, idle, timeout;

    // Winner selection and grant pulses, forced low while in reset.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        data_win  = d_req & (~i_req | (streak_q != STREAK_MAX));
        fetch_win = i_req & ~data_win;
        i_gnt     = arst_n & idle & fetch_win;
        d_gnt     = arst_n & idle & data_win;
        timeout   = WD_EN & ~m_ack & (wd_q == WD_LAST);
    end

    // FSM, watchdog and completion/abort pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            wd_q       <= 16'd0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_gnt || d_gnt) begin
                        state_q <= ST_BUSY;
                        owner_q <= d_gnt;
                        wd_q    <= 16'd0;
                    end
                end
                ST_BUSY: begin
                    if (m_ack || timeout) begin
                        state_q    <= ST_IDLE;
                        d_rvalid_q <= owner_q;
                        i_rvalid_q <= ~owner_q;
                        bus_err_q  <= ~m_ack;
                    end else if (WD_EN) begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Streak of data grants won while fetch was waiting.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            streak_q <= 4'd0;
        end else if (d_gnt) begin
            if (!i_req) begin
                streak_q <= 4'd0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 4'd1;
            end
        end else if (i_gnt) begin
            streak_q <= 4'd0;
        end
    end

    // Capture the winner's request fields; they persist after the transaction.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_addr_q  <= 32'd0;
            m_we_bs_q <= 4'd0;
            m_wdata_q <= 32'd0;
        end else if (d_gnt) begin
            m_addr_q  <= d_addr;
            m_we_bs_q <= d_we_bs;
            m_wdata_q <= d_wdata;
        end else if (i_gnt) begin
            m_addr_q  <= {i_addr, 2'b00};
            m_we_bs_q <= 4'd0;
            m_wdata_q <= 32'd0;
        end
    end

    // Read data registers: change only on read completion or abort.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else if (state_q == ST_BUSY) begin
            if (m_ack) begin
                if (!owner_q) begin
                    i_rdata_q <= m_rdata;
                end else if (m_we_bs_q == 4'd0) begin
                    d_rdata_q <= m_rdata;
                end
            end else if (timeout) begin
                if (owner_q) begin
                    d_rdata_q <= 32'd0;
                end else begin
                    i_rdata_q <= FETCH_NOP;
                end
            end
        end
    end

    // Output drive.
    always_comb begin
        m_req    = (state_q == ST_BUSY);
        m_addr   = m_addr_q;
        m_we_bs  = m_we_bs_q;
        m_wdata  = m_wdata_q;
        i_rvalid = i_rvalid_q;
        i_rdata  = i_rdata_q;
        d_rvalid = d_rvalid_q;
        d_rdata  = d_rdata_q;
        bus_err  = bus_err_q;
    end

endmodule

// File: tb/tb_edubos5_mem_arb.sv
// Self-checking bench for edubos5_mem_arb: directed scenarios plus a random
// traffic run checked against a transaction-level model of the arbiter.
module tb_edubos5_mem_arb;

    localparam int unsigned MaxStreak  = 4;
    localparam int unsigned AckTimeout = 8;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [29:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_we_bs;
    logic        m_req, m_ack, bus_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_we_bs;

    int n_checks = 0;
    int n_fails  = 0;

    // Memory model: absent words read back as an address-derived pattern.
    logic [31:0] mem [bit [29:0]];
    int ack_mode = 0;  // >=0 fixed delay, -1 never ack, -2 random 0..3
    int resp_cnt = 0;
    int resp_dly = 0;

    // Previous-sample state for the protocol monitor.
    logic        p_mreq = 0, p_mack = 0, p_ireq = 0, p_igrant = 0, p_dreq = 0, p_dgrant = 0;
    logic [29:0] p_iaddr = '0;
    logic [67:0] p_dfields = '0;

    edubos5_mem_arb #(.MAX_DATA_STREAK(MaxStreak), .ACK_TIMEOUT(AckTimeout)) dut (
        .clk(clk), .arst_n(arst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we_bs(d_we_bs), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_we_bs(m_we_bs), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Advance to just after the rising edge and run the memory responder.
    task automatic step();
        @(posedge clk);
        #1;
        m_ack   = 1'b0;
        m_rdata = $urandom;
        if (arst_n && m_req) begin
            if (resp_cnt == 0) resp_dly = (ack_mode == -2) ? int'($urandom_range(0, 3)) : ack_mode;
            if (resp_dly >= 0 && resp_cnt == resp_dly) begin
                m_ack   = 1'b1;
                m_rdata = mem_rd(m_addr[31:2]);
                if (m_we_bs != 4'd0) mem[m_addr[31:2]] = merge(mem_rd(m_addr[31:2]), m_wdata, m_we_bs);
            end
            resp_cnt++;
        end else begin
            resp_cnt = 0;
        end
    endtask

    // Sample on the falling edge and run the protocol monitor.
    task automatic sample();
        @(negedge clk);
        if (arst_n) begin
            n_checks++;
            if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid)) begin
                n_fails++;
                $display("FAIL exclusive: gnt i/d=%b/%b rvalid i/d=%b/%b, required at most one",
                         i_gnt, d_gnt, i_rvalid, d_rvalid);
            end
            n_checks++;
            if (p_mreq && !m_req && !p_mack && !bus_err) begin
                n_fails++;
                $display("FAIL mreq_drop: m_req fell without m_ack or bus_err, required held");
            end
            if (p_ireq && !p_igrant) begin
                n_checks++;
                if (!i_req || i_addr !== p_iaddr) begin
                    n_fails++;
                    $display("FAIL i_req_hold: req=%b addr=%h, required 1/%h", i_req, i_addr, p_iaddr);
                end
            end
            if (p_dreq && !p_dgrant) begin
                n_checks++;
                if (!d_req || {d_addr, d_we_bs, d_wdata} !== p_dfields) begin
                    n_fails++;
                    $display("FAIL d_req_hold: req=%b fields changed while pending", d_req);
                end
            end
        end
        p_mreq    = m_req && arst_n;
        p_mack    = m_ack;
        p_ireq    = i_req && arst_n;
        p_igrant  = i_gnt;
        p_iaddr   = i_addr;
        p_dreq    = d_req && arst_n;
        p_dgrant  = d_gnt;
        p_dfields = {d_addr, d_we_bs, d_wdata};
    endtask

    // One complete transaction on either port; returns read data and abort flag.
    task automatic xact(input logic is_d, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int k;
        step();
        if (is_d) begin
            d_req = 1; d_addr = addr; d_we_bs = be; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = addr[31:2];
        end
        sample();
        k = 0;
        while (!(is_d ? d_gnt : i_gnt) && k < 50) begin step(); sample(); k++; end
        step();
        if (is_d) d_req = 0; else i_req = 0;
        sample();
        while (!(is_d ? d_rvalid : i_rvalid) && k < 100) begin step(); sample(); k++; end
        if (k >= 100) begin
            n_checks++; n_fails++;
            $display("FAIL xact_timeout: no gnt/rvalid within bound, required completion");
        end
        rd  = is_d ? d_rdata : i_rdata;
        err = bus_err;
    endtask

    task automatic test_reset();
        arst_n = 0; i_req = 1; d_req = 1; i_addr = 30'h55; d_addr = 32'h100;
        d_we_bs = 4'hF; d_wdata = 32'h1; m_ack = 0; m_rdata = 0;
        #3;
        n_checks++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_addr, m_we_bs,
             m_wdata, bus_err} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: gnt=%b%b m_req=%b m_addr=%h, required all 0",
                     i_gnt, d_gnt, m_req, m_addr);
        end
        step(); step();
        i_req = 0; d_req = 0; d_we_bs = 0; arst_n = 1;
        sample();
        n_checks++;
        if (m_req !== 1'b0 || bus_err !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: m_req=%b bus_err=%b, required 0/0", m_req, bus_err);
        end
    endtask

    task automatic test_fetch();
        ack_mode = 0;
        mem[30'h40] = 32'h00A0_0093;
        step(); i_req = 1; i_addr = 30'h0000_0040;
        sample();
        n_checks++;
        if (i_gnt !== 1'b1) begin
            n_fails++; $display("FAIL fetch_gnt: i_gnt=%b, required 1", i_gnt);
        end
        step(); i_req = 0;
        sample();
        n_checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h0000_0100 || m_we_bs !== 4'd0) begin
            n_fails++;
            $display("FAIL fetch_bus: m_req=%b m_addr=%h we=%b, required 1/00000100/0000",
                     m_req, m_addr, m_we_bs);
        end
        step(); sample();
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h00A0_0093 || m_req !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_rvalid: rvalid=%b rdata=%h m_req=%b, required 1/00a00093/0",
                     i_rvalid, i_rdata, m_req);
        end
    endtask

    task automatic test_store();
        logic [31:0] rd;
        logic        err;
        mem[32'h3000 >> 2] = 32'h1234_5678;
        mem[32'h2004 >> 2] = 32'h1122_3344;
        xact(1'b1, 32'h3000, 4'd0, 32'd0, rd, err);
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_fails++; $display("FAIL load_prior: d_rdata=%h, required 12345678", rd);
        end
        step(); d_req = 1; d_addr = 32'h2004; d_we_bs = 4'b1100; d_wdata = 32'hDEAD_BEEF;
        sample();
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fails++; $display("FAIL store_gnt: d_gnt=%b, required 1", d_gnt);
        end
        step(); d_req = 0;
        sample();
        n_checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h2004 || m_we_bs !== 4'b1100 || m_wdata !== 32'hDEAD_BEEF) begin
            n_fails++;
            $display("FAIL store_bus: m_addr=%h we=%b wdata=%h, required 00002004/1100/deadbeef",
                     m_addr, m_we_bs, m_wdata);
        end
        step(); sample();
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678 || bus_err !== 1'b0) begin
            n_fails++;
            $display("FAIL store_done: rvalid=%b rdata=%h err=%b, required 1/12345678/0",
                     d_rvalid, d_rdata, bus_err);
        end
        xact(1'b1, 32'h2004, 4'd0, 32'd0, rd, err);
        n_checks++;
        if (rd !== 32'hDEAD_3344) begin
            n_fails++; $display("FAIL store_merge: read %h, required dead3344", rd);
        end
    endtask

    task automatic test_streak();
        int ng, last, k;
        logic g_i, g_d, exp_d;
        ack_mode = 0;
        step(); i_req = 1; i_addr = 30'h80; d_req = 1; d_addr = 32'h3000; d_we_bs = 0;
        sample();
        ng = 0; last = 0; k = 0;
        while ((i_req || d_req) && k < 60) begin
            if (i_gnt || d_gnt) begin
                if (ng < 10) begin
                    exp_d = ((ng % 5) != 4);
                    n_checks++;
                    if (d_gnt !== exp_d) begin
                        n_fails++;
                        $display("FAIL streak_order[%0d]: d_gnt=%b, required %b", ng, d_gnt, exp_d);
                    end
                    if (ng > 0) begin
                        n_checks++;
                        if (k - last != 2) begin
                            n_fails++;
                            $display("FAIL streak_gap[%0d]: %0d cycles, required 2", ng, k - last);
                        end
                    end
                    last = k;
                end
                ng++;
            end
            g_i = i_gnt; g_d = d_gnt;
            step();
            if (ng >= 10) begin
                if (g_i) i_req = 0;
                if (g_d) d_req = 0;
            end
            sample();
            k++;
        end
        n_checks++;
        if (ng < 10) begin
            n_fails++; $display("FAIL streak_count: %0d grants, required >= 10", ng);
        end
        repeat (3) begin step(); sample(); end
    endtask

    task automatic test_timeout();
        int nreq;
        logic [31:0] rd;
        logic        err;
        ack_mode = -1;
        step(); d_req = 1; d_addr = 32'h3000; d_we_bs = 0;
        sample();
        step(); d_req = 0;
        sample();
        nreq = 0;
        while (m_req && nreq < 40) begin nreq++; step(); sample(); end
        n_checks++;
        if (nreq != 8) begin
            n_fails++; $display("FAIL timeout_len: m_req high %0d cycles, required 8", nreq);
        end
        n_checks++;
        if (bus_err !== 1'b1 || d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'd0) begin
            n_fails++;
            $display("FAIL timeout_abort: err=%b d_rvalid=%b i_rvalid=%b d_rdata=%h, required 1/1/0/0",
                     bus_err, d_rvalid, i_rvalid, d_rdata);
        end
        ack_mode = 0;
        step(); i_req = 1; i_addr = 30'h44;
        sample();
        n_checks++;
        if (i_gnt !== 1'b1 || bus_err !== 1'b0) begin
            n_fails++; $display("FAIL timeout_regrant: i_gnt=%b err=%b, required 1/0", i_gnt, bus_err);
        end
        step(); i_req = 0; sample();
        step(); sample();
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== mem_rd(30'h44)) begin
            n_fails++;
            $display("FAIL timeout_next: rvalid=%b rdata=%h, required 1/%h", i_rvalid, i_rdata, mem_rd(30'h44));
        end
        ack_mode = -1;
        xact(1'b0, 32'h0000_0200, 4'd0, 32'd0, rd, err);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'h0000_0013) begin
            n_fails++; $display("FAIL fetch_abort: err=%b rdata=%h, required 1/00000013", err, rd);
        end
        ack_mode = 0;
    endtask

    task automatic test_ack_at_timeout();
        int nreq;
        logic anyerr;
        logic [31:0] exp;
        exp = mem_rd(30'(32'h3000 >> 2));
        ack_mode = 7;
        step(); d_req = 1; d_addr = 32'h3000; d_we_bs = 0;
        sample();
        step(); d_req = 0;
        sample();
        nreq = 0; anyerr = 0;
        while (m_req && nreq < 40) begin nreq++; step(); sample(); anyerr |= bus_err; end
        n_checks++;
        if (nreq != 8 || anyerr !== 1'b0) begin
            n_fails++;
            $display("FAIL ack_edge_len: m_req %0d cycles err=%b, required 8/0", nreq, anyerr);
        end
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== exp) begin
            n_fails++;
            $display("FAIL ack_edge_data: rvalid=%b rdata=%h, required 1/%h", d_rvalid, d_rdata, exp);
        end
        ack_mode = 0;
    endtask

    task automatic test_reset_mid();
        int nd, k;
        logic anyout;
        ack_mode = 0;
        step(); i_req = 1; i_addr = 30'h90; d_req = 1; d_addr = 32'h3000; d_we_bs = 0;
        sample();
        nd = 0; k = 0;
        while (nd < 4 && k < 40) begin
            if (d_gnt) nd++;
            if (nd == 4) ack_mode = -1;
            else begin step(); sample(); end
            k++;
        end
        step(); d_req = 0; sample();
        step(); sample();
        n_checks++;
        if (m_req !== 1'b1) begin
            n_fails++; $display("FAIL mid_busy: m_req=%b, required 1", m_req);
        end
        step();
        arst_n = 0;
        #1;
        n_checks++;
        if ({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_addr, m_we_bs, m_wdata, bus_err} !== '0) begin
            n_fails++;
            $display("FAIL mid_reset_outputs: gnt=%b%b m_req=%b m_addr=%h, required all 0",
                     i_gnt, d_gnt, m_req, m_addr);
        end
        i_req = 0;
        sample();
        step(); arst_n = 1; ack_mode = 0;
        anyout = 0;
        repeat (5) begin sample(); anyout |= i_rvalid | d_rvalid | bus_err; step(); end
        n_checks++;
        if (anyout !== 1'b0) begin
            n_fails++; $display("FAIL mid_silent: rvalid/bus_err seen after reset, required none");
        end
        i_req = 1; d_req = 1;
        sample();
        n_checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_streak: gnt i/d=%b/%b, required 0/1 (streak cleared)", i_gnt, d_gnt);
        end
        step(); d_req = 0; sample();
        k = 0;
        while (!i_gnt && k < 20) begin step(); sample(); k++; end
        step(); i_req = 0; sample();
        repeat (3) begin step(); sample(); end
    endtask

    task automatic test_random();
        logic        busy, pend_d, pend_wr, d_known, g_i, g_d, exp_d, exp_any;
        logic [31:0] pend_exp, pend_addr, pend_wd, last_d, got, exp;
        logic [3:0]  pend_be;
        logic [1:0]  exp_g;
        int          streak_m, ngr;
        busy = 0; d_known = 0; streak_m = 0; ngr = 0; g_i = 0; g_d = 0;
        pend_d = 0; pend_wr = 0; pend_exp = 0; pend_addr = 0; pend_wd = 0; pend_be = 0; last_d = 0;
        ack_mode = -2;
        for (int c = 0; c < 320; c++) begin
            step();
            if (g_i) i_req = 0;
            if (g_d) d_req = 0;
            if (!i_req && c < 290 && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_addr = {20'h0, 10'($urandom)};
            end
            if (!d_req && c < 290 && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_addr = {20'h0, 10'($urandom), 2'b00}; d_wdata = $urandom;
                d_we_bs = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            end
            sample();
            if (i_rvalid || d_rvalid) begin
                n_checks++;
                if (!busy || d_rvalid !== pend_d) begin
                    n_fails++;
                    $display("FAIL rnd_owner: rvalid i/d=%b/%b, required owner d=%b busy=%b",
                             i_rvalid, d_rvalid, pend_d, busy);
                end else if (!(pend_d && pend_wr && !d_known)) begin
                    got = pend_d ? d_rdata : i_rdata;
                    exp = (pend_d && pend_wr) ? last_d : pend_exp;
                    n_checks++;
                    if (got !== exp) begin
                        n_fails++;
                        $display("FAIL rnd_rdata: port d=%b wr=%b got %h, required %h",
                                 pend_d, pend_wr, got, exp);
                    end
                end
                if (pend_d && !pend_wr) begin last_d = pend_exp; d_known = 1; end
                busy = 0;
            end
            exp_any = !busy && (i_req || d_req);
            exp_d   = d_req && (!i_req || streak_m < int'(MaxStreak));
            exp_g   = exp_any ? (exp_d ? 2'b01 : 2'b10) : 2'b00;
            n_checks++;
            if ({i_gnt, d_gnt} !== exp_g) begin
                n_fails++;
                $display("FAIL rnd_grant: gnt i/d=%b%b, required %b (streak %0d)",
                         i_gnt, d_gnt, exp_g, streak_m);
            end
            if (exp_any) begin
                busy = 1; ngr++; pend_d = exp_d;
                streak_m  = (exp_d && i_req) ? streak_m + 1 : 0;
                pend_addr = exp_d ? d_addr : {i_addr, 2'b00};
                pend_be   = exp_d ? d_we_bs : 4'd0;
                pend_wd   = exp_d ? d_wdata : 32'd0;
                pend_wr   = (pend_be != 4'd0);
                pend_exp  = mem_rd(pend_addr[31:2]);
            end else if (busy) begin
                n_checks++;
                if (m_req !== 1'b1 || m_addr !== pend_addr || m_we_bs !== pend_be || m_wdata !== pend_wd) begin
                    n_fails++;
                    $display("FAIL rnd_bus: req=%b addr=%h be=%b wd=%h, required 1/%h/%b/%h",
                             m_req, m_addr, m_we_bs, m_wdata, pend_addr, pend_be, pend_wd);
                end
            end
            g_i = i_gnt; g_d = d_gnt;
        end
        n_checks++;
        if (ngr < 40 || busy || i_req || d_req) begin
            n_fails++;
            $display("FAIL rnd_progress: %0d grants busy=%b, required >=40 and drained", ngr, busy);
        end
        ack_mode = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_streak();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
